// File: rtl/keypad_pkg.sv
// keypad_pkg
//  Shared definitions for the 4x4 matrix keypad scanner.
//  - scan_state_e : scanner state machine encoding (SCAN, DEBOUNCE, PRESSED)
//  - COL_0..COL_3 : one-hot-low column drive patterns, scanned in that order
//  - col_next     : next column in the scan rotation
//  - col_index    : column pattern -> column number 0..3
//  - key_map      : (row, column) -> hex key code, laid out like a phone/ATM pad
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } scan_state_e;

  localparam logic [3:0] COL_0 = 4'b1110;
  localparam logic [3:0] COL_1 = 4'b1101;
  localparam logic [3:0] COL_2 = 4'b1011;
  localparam logic [3:0] COL_3 = 4'b0111;

  // An unexpected pattern restarts the rotation at column 0, so a corrupted
  // drive register heals itself on the next scan step.
  function automatic logic [3:0] col_next(input logic [3:0] col_n);
    logic [3:0] nxt;
    case (col_n)
      COL_0:   nxt = COL_1;
      COL_1:   nxt = COL_2;
      COL_2:   nxt = COL_3;
      default: nxt = COL_0;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] col_n);
    logic [1:0] idx;
    case (col_n)
      COL_1:   idx = 2'd1;
      COL_2:   idx = 2'd2;
      COL_3:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Row 3 carries '*' and '#', reported as E and F so every key has a hex code.
  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen
//  Free-running divider producing a one-cycle tick every 2^SCAN_DIV_BITS clocks.
//  Shared with the multiplexed display driver so both sides step at the same rate.
// Ports
//  clk  : system clock
//  rst  : synchronous active-high reset, clears the divider
//  tick : high for one cycle whenever the divider is all-ones
module scan_tick_gen #(
  parameter int SCAN_DIV_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [SCAN_DIV_BITS-1:0] DIV_ONE = {{(SCAN_DIV_BITS-1){1'b0}}, 1'b1};

  logic [SCAN_DIV_BITS-1:0] div_q;

  // The divider wraps naturally; no terminal-count reload is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_ONE;
    end
  end

  assign tick = &div_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//  Scans a 4x4 matrix keypad one column at a time, debounces presses and
//  releases on scan ticks, and reports accepted keys as hex codes. The last four
//  keys are kept in a 16-bit buffer shaped like the display driver's nums bus.
// Ports
//  clk       : system clock
//  rst       : synchronous active-high reset
//  row_n     : keypad rows, active-low, asynchronous to clk
//  col_n     : column drive, one-hot-low
//  clr       : synchronous clear of key_buf
//  key_code  : last accepted key
//  key_valid : one-cycle strobe when a new key is accepted
//  key_down  : high while an accepted key is held
//  key_buf   : last four keys, newest in [3:0]
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 16,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  input  logic        clr,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [15:0] key_buf
);

  localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_TICKS);
  localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

  logic              tick;
  logic [3:0]        row_meta_q;
  logic [3:0]        row_s_q;
  scan_state_e       state_q;
  logic [3:0]        col_n_q;
  logic [3:0]        cand_q;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic [3:0]        key_code_q;
  logic              key_valid_q;
  logic              key_down_q;
  logic [15:0]       key_buf_q;
  logic [15:0]       key_buf_d;

  logic              key_hit;
  logic [1:0]        row_idx;
  logic [3:0]        seen_key;
  logic [DEB_W-1:0]  deb_inc;
  logic              accept;

  scan_tick_gen #(
    .SCAN_DIV_BITS(SCAN_DIV_BITS)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Two-flop synchroniser; idle (all rows high) after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= row_n;
      row_s_q    <= row_meta_q;
    end
  end

  // When several rows are low in the driven column, the lowest row wins.
  always_comb begin
    row_idx = 2'd0;
    if (!row_s_q[0]) begin
      row_idx = 2'd0;
    end else if (!row_s_q[1]) begin
      row_idx = 2'd1;
    end else if (!row_s_q[2]) begin
      row_idx = 2'd2;
    end else if (!row_s_q[3]) begin
      row_idx = 2'd3;
    end
  end

  assign key_hit  = (row_s_q != 4'hF);
  assign seen_key = {row_idx, col_index(col_n_q)};

  // The shared counter saturates so it can never wrap back to a small value.
  assign deb_inc = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + DEB_ONE;

  assign accept = tick && (state_q == DEBOUNCE) && key_hit &&
                  (seen_key == cand_q) && (deb_inc == DEB_MAX);

  // A clear coinciding with an accept keeps only the new key.
  always_comb begin
    key_buf_d = key_buf_q;
    if (accept) begin
      key_buf_d = clr ? {12'h000, key_map(cand_q[3:2], cand_q[1:0])}
                      : {key_buf_q[11:0], key_map(cand_q[3:2], cand_q[1:0])};
    end else if (clr) begin
      key_buf_d = 16'h0000;
    end
  end

  // Scanner state machine. deb_cnt_q counts matching samples while debouncing
  // a press and consecutive empty samples while waiting for a release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      col_n_q     <= COL_0;
      cand_q      <= 4'h0;
      deb_cnt_q   <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      key_buf_q   <= 16'h0000;
    end else begin
      key_valid_q <= accept;
      key_buf_q   <= key_buf_d;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (!key_hit) begin
              col_n_q <= col_next(col_n_q);
            end else begin
              cand_q    <= seen_key;
              deb_cnt_q <= DEB_ONE;
              state_q   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (key_hit && (seen_key == cand_q)) begin
              if (accept) begin
                key_code_q <= key_map(cand_q[3:2], cand_q[1:0]);
                key_down_q <= 1'b1;
                deb_cnt_q  <= '0;
                state_q    <= PRESSED;
              end else begin
                deb_cnt_q <= deb_inc;
              end
            end else begin
              deb_cnt_q <= '0;
              state_q   <= SCAN;
            end
          end
          PRESSED: begin
            if (key_hit) begin
              deb_cnt_q <= '0;
            end else if (deb_inc == DEB_MAX) begin
              key_down_q <= 1'b0;
              deb_cnt_q  <= '0;
              state_q    <= SCAN;
            end else begin
              deb_cnt_q <= deb_inc;
            end
          end
          default: begin
            deb_cnt_q <= '0;
            state_q   <= SCAN;
          end
        endcase
      end
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign key_buf   = key_buf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//  Directed bench for keypad_scanner with a 4-clock scan tick and 3-sample
//  debounce. A keypad model pulls row r low whenever a pressed key (r,c) sits in
//  the driven column. A tick-level behavioural model predicts every output each
//  cycle; literal expectations in the test sequence pin that model down.
module tb_keypad_scanner;

  localparam int SCAN_DIV_BITS  = 2;
  localparam int DEBOUNCE_TICKS = 3;
  localparam int TICK_CYCLES    = 1 << SCAN_DIV_BITS;
  localparam int RELEASE_WAIT   = 6 * TICK_CYCLES;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        clr;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] key_buf;

  bit pressed [16];
  int errors = 0;
  int checks = 0;
  int pulseCount = 0;

  // Behavioural model state
  bit          modelLive = 1'b0;
  int          mDiv;
  int          mCol;
  logic [3:0]  mSync1;
  logic [3:0]  mSync2;
  int          mCand;
  int          mStreak;
  bit          mHeld;
  int          mRel;
  logic [3:0]  mCode;
  bit          mValid;
  bit          mDown;
  logic [15:0] mBuf;

  logic [3:0] keyMap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(
    .SCAN_DIV_BITS (SCAN_DIV_BITS),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .clr      (clr),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down),
    .key_buf  (key_buf)
  );

  initial forever #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!col_n[c] && pressed[r*4+c]) row_n[r] = 1'b0;
      end
    end
  end

  function automatic logic [3:0] keypadRows(input int col);
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (pressed[r*4+col]) rows[r] = 1'b0;
    end
    return rows;
  endfunction

  function automatic int decodeRows(input logic [3:0] rows, input int col);
    for (int r = 0; r < 4; r++) begin
      if (!rows[r]) return r*4 + col;
    end
    return -1;
  endfunction

  // Model: decisions once per tick from the two-cycle-delayed row sample.
  always @(posedge clk) begin
    logic [3:0] raw;
    int seen;
    bit accepted;
    if (rst === 1'b1) begin
      mDiv = 0; mCol = 0; mSync1 = 4'hF; mSync2 = 4'hF;
      mCand = -1; mStreak = 0; mHeld = 0; mRel = 0;
      mCode = 4'h0; mValid = 0; mDown = 0; mBuf = 16'h0000;
      modelLive = 1'b1;
    end else if (modelLive) begin
      raw = keypadRows(mCol);
      accepted = 1'b0;
      if (mDiv == TICK_CYCLES - 1) begin
        seen = decodeRows(mSync2, mCol);
        if (mHeld) begin
          if (seen < 0) begin
            mRel++;
            if (mRel == DEBOUNCE_TICKS) begin
              mHeld = 0; mDown = 0; mRel = 0;
            end
          end else begin
            mRel = 0;
          end
        end else if (mCand < 0) begin
          if (seen < 0) mCol = (mCol + 1) % 4;
          else begin mCand = seen; mStreak = 1; end
        end else if (seen == mCand) begin
          mStreak++;
          if (mStreak == DEBOUNCE_TICKS) begin
            accepted = 1'b1;
            mCode = keyMap[mCand];
            mDown = 1; mHeld = 1; mRel = 0; mCand = -1;
          end
        end else begin
          mCand = -1;
        end
      end
      mValid = accepted;
      if (accepted) mBuf = (clr === 1'b1) ? {12'h000, mCode} : {mBuf[11:0], mCode};
      else if (clr === 1'b1) mBuf = 16'h0000;
      mSync2 = mSync1;
      mSync1 = raw;
      mDiv = (mDiv + 1) % TICK_CYCLES;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    if (modelLive) begin
      checkOutput("col_n", {12'h0, col_n}, {12'h0, ~(4'b0001 << mCol)});
      checkOutput("key_valid", {15'h0, key_valid}, {15'h0, mValid});
      checkOutput("key_code", {12'h0, key_code}, {12'h0, mCode});
      checkOutput("key_down", {15'h0, key_down}, {15'h0, mDown});
      checkOutput("key_buf", key_buf, mBuf);
      if (key_valid === 1'b1) pulseCount++;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int r, input int c, input bit down);
    pressed[r*4+c] = down;
  endtask

  task automatic waitForPulse(input int limit, output int waited, output bit seen);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < limit) begin
      @(negedge clk);
      waited++;
      if (key_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic pressAndRelease(input int r, input int c, input logic [3:0] code);
    int waited;
    bit seen;
    applyStimulus(r, c, 1'b1);
    waitForPulse(120, waited, seen);
    checkOutput($sformatf("pulse_r%0dc%0d", r, c), {15'h0, seen}, 16'h0001);
    checkOutput($sformatf("code_r%0dc%0d", r, c), {12'h0, key_code}, {12'h0, code});
    applyStimulus(r, c, 1'b0);
    waitCycles(RELEASE_WAIT);
  endtask

  initial begin
    int waited;
    int n;
    bit seen;
    logic [3:0] colSeq [3];
    colSeq = '{4'b1011, 4'b0111, 4'b1110};
    rst = 1'b1;
    clr = 1'b0;
    for (int i = 0; i < 16; i++) pressed[i] = 1'b0;
    waitCycles(3);

    // 1: reset values and idle column rotation
    checkOutput("reset_col", {12'h0, col_n}, 16'h000E);
    checkOutput("reset_code", {12'h0, key_code}, 16'h0000);
    checkOutput("reset_buf", key_buf, 16'h0000);
    checkOutput("reset_down", {15'h0, key_down}, 16'h0000);
    rst = 1'b0;
    waitCycles(3);
    checkOutput("col_before_tick", {12'h0, col_n}, 16'h000E);
    waitCycles(1);
    checkOutput("col_step1", {12'h0, col_n}, 16'h000D);
    for (int i = 0; i < 3; i++) begin
      waitCycles(TICK_CYCLES);
      checkOutput($sformatf("col_step%0d", i + 2), {12'h0, col_n}, {12'h0, colSeq[i]});
    end
    checkOutput("idle_no_pulse", pulseCount[15:0], 16'd0);

    // 2: hold '5'
    applyStimulus(1, 1, 1'b1);
    waitForPulse(120, waited, seen);
    checkOutput("pulse_5", {15'h0, seen}, 16'h0001);
    checkOutput("code_5", {12'h0, key_code}, 16'h0005);
    checkOutput("buf_5", key_buf, 16'h0005);
    waitCycles(40);
    checkOutput("held_single_pulse", pulseCount[15:0], 16'd1);
    checkOutput("held_down", {15'h0, key_down}, 16'h0001);
    applyStimulus(1, 1, 1'b0);
    waitCycles(TICK_CYCLES);
    checkOutput("down_just_after_release", {15'h0, key_down}, 16'h0001);
    waitCycles(RELEASE_WAIT);
    checkOutput("down_after_release", {15'h0, key_down}, 16'h0000);

    // 3: 1, 2, 3, A, 0
    pressAndRelease(0, 0, 4'h1);
    pressAndRelease(0, 1, 4'h2);
    pressAndRelease(0, 2, 4'h3);
    pressAndRelease(0, 3, 4'hA);
    pressAndRelease(3, 1, 4'h0);
    checkOutput("buf_seq", key_buf, 16'h23A0);
    checkOutput("pulses_seq", pulseCount[15:0], 16'd6);

    // 4: bounce on '7', aligned to the column-0 dwell
    n = 0;
    while (col_n == 4'b1110 && n < 100) begin @(negedge clk); n++; end
    while (col_n != 4'b1110 && n < 100) begin @(negedge clk); n++; end
    checkOutput("col0_reached", {15'h0, (n < 100)}, 16'h0001);
    applyStimulus(2, 0, 1'b1);
    waitCycles(2 * TICK_CYCLES);
    applyStimulus(2, 0, 1'b0);
    waitCycles(TICK_CYCLES);
    applyStimulus(2, 0, 1'b1);
    checkOutput("bounce_no_pulse", pulseCount[15:0], 16'd6);
    waitForPulse(60, waited, seen);
    checkOutput("bounce_pulse", {15'h0, seen}, 16'h0001);
    checkOutput("bounce_latency", waited[15:0], 16'd12);
    checkOutput("bounce_code", {12'h0, key_code}, 16'h0007);
    applyStimulus(2, 0, 1'b0);
    waitCycles(RELEASE_WAIT);
    checkOutput("bounce_pulses", pulseCount[15:0], 16'd7);

    // 5: row priority, then a second key while one is held
    applyStimulus(0, 0, 1'b1);
    applyStimulus(3, 0, 1'b1);
    waitForPulse(120, waited, seen);
    checkOutput("prio_pulse", {15'h0, seen}, 16'h0001);
    checkOutput("prio_code", {12'h0, key_code}, 16'h0001);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(3, 0, 1'b0);
    waitCycles(RELEASE_WAIT);
    applyStimulus(0, 0, 1'b1);
    waitForPulse(120, waited, seen);
    checkOutput("hold1_pulse", {15'h0, seen}, 16'h0001);
    applyStimulus(2, 2, 1'b1);
    waitCycles(40);
    checkOutput("second_key_ignored", pulseCount[15:0], 16'd9);
    checkOutput("second_key_code", {12'h0, key_code}, 16'h0001);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(2, 2, 1'b0);
    waitCycles(RELEASE_WAIT);
    checkOutput("buf_after_prio", key_buf, 16'h0711);

    // 6: reset during debounce, then clear coinciding with an accept
    applyStimulus(1, 2, 1'b1);
    n = 0;
    while (mCand < 0 && n < 100) begin @(negedge clk); n++; end
    checkOutput("debounce_reached", {15'h0, (n < 100)}, 16'h0001);
    rst = 1'b1;
    applyStimulus(1, 2, 1'b0);
    waitCycles(1);
    checkOutput("rst_col", {12'h0, col_n}, 16'h000E);
    checkOutput("rst_code", {12'h0, key_code}, 16'h0000);
    checkOutput("rst_buf", key_buf, 16'h0000);
    checkOutput("rst_down", {15'h0, key_down}, 16'h0000);
    waitCycles(1);
    rst = 1'b0;
    waitCycles(40);
    checkOutput("rst_no_pulse", pulseCount[15:0], 16'd9);
    pressAndRelease(2, 2, 4'h9);
    checkOutput("buf_9", key_buf, 16'h0009);
    applyStimulus(3, 2, 1'b1);
    n = 0;
    while (!(mCand == 14 && mStreak == DEBOUNCE_TICKS - 1 && mDiv == TICK_CYCLES - 1) && n < 120) begin
      @(negedge clk); n++;
    end
    checkOutput("accept_edge_found", {15'h0, (n < 120)}, 16'h0001);
    clr = 1'b1;
    waitCycles(1);
    clr = 1'b0;
    checkOutput("clr_accept_valid", {15'h0, key_valid}, 16'h0001);
    checkOutput("clr_accept_buf", key_buf, 16'h000F);
    checkOutput("clr_accept_code", {12'h0, key_code}, 16'h000F);
    applyStimulus(3, 2, 1'b0);
    waitCycles(RELEASE_WAIT);
    clr = 1'b1;
    waitCycles(1);
    clr = 1'b0;
    checkOutput("clr_only_buf", key_buf, 16'h0000);
    checkOutput("total_pulses", pulseCount[15:0], 16'd11);

    waitCycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
